// File: rtl/acc_result_buffer_if.sv
// Write-strobe, read-port and status bundle between the systolic controller side
// and the result accumulator buffer.
interface acc_result_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              acc_clear;
    logic              acc_wr_en;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic              acc_wr_col01;
    logic              acc_wr_col2;
    logic              acc_accumulate;
    logic [DATA_W-1:0] col0_in;
    logic [DATA_W-1:0] col1_in;
    logic [DATA_W-1:0] col2_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_pending;
    logic              sat_flag;

    modport master (
        output acc_clear, acc_wr_en, acc_wr_addr, acc_wr_col01, acc_wr_col2,
               acc_accumulate, col0_in, col1_in, col2_in, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_pending, sat_flag
    );

    modport slave (
        input  acc_clear, acc_wr_en, acc_wr_addr, acc_wr_col01, acc_wr_col2,
               acc_accumulate, col0_in, col1_in, col2_in, rd_en, rd_addr,
        output rd_data, rd_valid, wr_pending, sat_flag
    );
endinterface

// File: rtl/acc_result_buffer.sv
// Result accumulator buffer: two-stage write (capture, then read-modify-write with
// saturating add), flash clear via a valid-bit vector, and a registered read port.
module acc_result_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_result_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  wr_hit;

    logic              toggle_q, toggle_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_acc_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              sat_q;

    logic              accept;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W:0]   sum;
    logic              ovf;
    logic [DATA_W-1:0] sat_val;
    logic [DATA_W-1:0] new_val;
    logic              mem_we;

    // col2 wins over col01; a strobe-less request is silently dropped
    assign accept = bus.acc_wr_en && (bus.acc_wr_col2 || bus.acc_wr_col01);

    always_comb begin
        s1_valid_d = accept;
        s1_data_d  = bus.col2_in;
        toggle_d   = toggle_q;
        if (accept) begin
            if (bus.acc_wr_col2) begin
                s1_data_d = bus.col2_in;
                toggle_d  = 1'b0;
            end else begin
                s1_data_d = toggle_q ? bus.col1_in : bus.col0_in;
                toggle_d  = ~toggle_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s1_acc_q   <= 1'b0;
        end else begin
            toggle_q   <= toggle_d;
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_addr_q <= bus.acc_wr_addr;
                s1_data_q <= s1_data_d;
                s1_acc_q  <= bus.acc_accumulate;
            end
        end
    end

    // Stage 2: the previous write has already landed, so a plain array read is exact
    assign old_val = valid_q[s1_addr_q] ? mem_q[s1_addr_q] : '0;
    assign sum     = {old_val[DATA_W-1], old_val} + {s1_data_q[DATA_W-1], s1_data_q};
    assign ovf     = sum[DATA_W] ^ sum[DATA_W-1];
    assign sat_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    assign new_val = !s1_acc_q ? s1_data_q : (ovf ? sat_val : sum[DATA_W-1:0]);
    assign mem_we  = s1_valid_q && !bus.acc_clear;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[s1_addr_q] <= new_val;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi] = mem_we && (s1_addr_q == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sat_q   <= 1'b0;
        end else if (bus.acc_clear) begin
            valid_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= valid_q | wr_hit;
            if (s1_valid_q && s1_acc_q && ovf) begin
                sat_q <= 1'b1;
            end
        end
    end

    // Sampled before this edge's write/clear, so same-cycle reads see old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= valid_q[bus.rd_addr] ? mem_q[bus.rd_addr] : '0;
            end
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_pending = s1_valid_q;
    assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_acc_result_buffer.sv
// Directed bench for acc_result_buffer: a per-cycle vector table plus a hand-written
// asynchronous-reset-mid-burst sequence.
module tb_acc_result_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    acc_result_buffer_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    acc_result_buffer #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        clr, wr, c01, c2, acc;
        logic [7:0]  wa;
        logic [31:0] d0, d1, d2;
        logic        rd;
        logic [7:0]  ra;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_pend, e_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic wr, logic c01, logic c2, logic acc,
                                logic [7:0] wa, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic rd, logic [7:0] ra, logic e_rv,
                                logic [31:0] e_rd, logic e_pend, logic e_sat);
        vec_t v;
        v.clr = clr; v.wr = wr; v.c01 = c01; v.c2 = c2; v.acc = acc; v.wa = wa;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.rd = rd; v.ra = ra;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_pend = e_pend; v.e_sat = e_sat;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.acc_clear      = v.clr;
        bus.acc_wr_en      = v.wr;
        bus.acc_wr_col01   = v.c01;
        bus.acc_wr_col2    = v.c2;
        bus.acc_accumulate = v.acc;
        bus.acc_wr_addr    = v.wa;
        bus.col0_in        = v.d0;
        bus.col1_in        = v.d1;
        bus.col2_in        = v.d2;
        bus.rd_en          = v.rd;
        bus.rd_addr        = v.ra;
    endtask

    task automatic run_vec(vec_t v, string tag);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check({tag, " rd_valid"}, {31'd0, bus.rd_valid}, {31'd0, v.e_rv});
        check({tag, " wr_pending"}, {31'd0, bus.wr_pending}, {31'd0, v.e_pend});
        check({tag, " sat_flag"}, {31'd0, bus.sat_flag}, {31'd0, v.e_sat});
        if (v.e_rv) check({tag, " rd_data"}, bus.rd_data, v.e_rd);
        $display("[TB] %s clr=%0b wr=%0b wa=%02h rd=%0b ra=%02h -> rv=%0b rd_data=%08h pend=%0b sat=%0b",
                 tag, v.clr, v.wr, v.wa, v.rd, v.ra, bus.rd_valid, bus.rd_data,
                 bus.wr_pending, bus.sat_flag);
    endtask

    // Column data used by col01 writes
    localparam logic [31:0] M7 = 32'hFFFF_FFF9;

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0, 8'h00, 0,0,0, 0,8'h00, 0,0,0,0);
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data", bus.rd_data, 32'd0);
        check("reset rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("reset wr_pending", {31'd0, bus.wr_pending}, 32'd0);
        check("reset sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic write/readback
        vecs.push_back(mk(1,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 8'h10, 5,M7,9,             0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,1,0,0, 8'h11, 5,M7,9,             0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,0,1,0, 8'h12, 5,M7,9,             0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h10, 1,5,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h11, 1,M7,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h12, 1,9,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        // accumulate: 100 + 23 - 50
        vecs.push_back(mk(0,1,0,1,0, 8'h20, 0,0,100,            0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,0,1,1, 8'h20, 0,0,23,             0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,0,1,1, 8'h20, 0,0,32'hFFFF_FFCE,  0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h20, 1,73,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h21, 1,0,0,0));
        // saturation, positive then negative
        vecs.push_back(mk(0,1,0,1,0, 8'h30, 0,0,32'h7FFF_FFF0,  0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,0,1,1, 8'h30, 0,0,32'h20,         0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h30, 1,32'h7FFF_FFFF,0,1));
        vecs.push_back(mk(0,1,0,1,0, 8'h31, 0,0,32'h8000_0005,  0,8'h00, 0,0,1,1));
        vecs.push_back(mk(0,1,0,1,1, 8'h31, 0,0,32'hFFFF_FFF6,  0,8'h00, 0,0,1,1));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h31, 1,32'h8000_0000,0,1));
        // clear semantics
        vecs.push_back(mk(0,1,0,1,0, 8'h00, 0,0,11,             0,8'h00, 0,0,1,1));
        vecs.push_back(mk(0,1,0,1,0, 8'h01, 0,0,22,             0,8'h00, 0,0,1,1));
        vecs.push_back(mk(0,1,0,1,0, 8'h02, 0,0,33,             0,8'h00, 0,0,1,1));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,1));
        vecs.push_back(mk(1,1,0,1,0, 8'h03, 0,0,44,             1,8'h00, 1,11,1,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(1,1,0,1,1, 8'h04, 0,0,55,             0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h00, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h01, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h02, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h03, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h04, 1,55,0,0));
        // read/write hazard: same-cycle read sees old value
        vecs.push_back(mk(0,1,0,1,0, 8'h40, 0,0,1,              0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              0,8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1,1, 8'h40, 0,0,2,              0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h40, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h40, 1,3,0,0));
        // column select: both strobes, dropped request, toggle behaviour
        vecs.push_back(mk(0,1,1,0,0, 8'h50, 32'h100,32'h200,32'h300, 0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,1,1,0, 8'h51, 32'h100,32'h200,32'h300, 0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,1,0,0, 8'h52, 32'h100,32'h200,32'h300, 0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,1,0,0,0, 8'h53, 32'h100,32'h200,32'h300, 0,8'h00, 0,0,0,0));
        vecs.push_back(mk(0,1,1,0,0, 8'h54, 32'h100,32'h200,32'h300, 0,8'h00, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h50, 1,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h51, 1,32'h300,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h52, 1,32'h100,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h53, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0, 8'h00, 0,0,0,              1,8'h54, 1,32'h200,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // async reset mid-burst, with sat_flag and rd_valid raised beforehand
        run_vec(mk(0,1,0,1,0, 8'h70, 0,0,32'h7FFF_FFFF, 0,8'h00, 0,0,1,0), "rst_a");
        run_vec(mk(0,1,0,1,1, 8'h70, 0,0,1,             0,8'h00, 0,0,1,0), "rst_b");
        run_vec(mk(0,1,1,0,0, 8'h60, 32'hA,32'hB,0,     1,8'h54, 1,32'h200,1,1), "rst_c");
        run_vec(mk(0,1,1,0,0, 8'h61, 32'hA,32'hB,0,     1,8'h54, 1,32'h200,1,1), "rst_d");
        #2;
        drive(idle);
        rst_n = 1'b0;
        #1;
        check("async rst rd_data", bus.rd_data, 32'd0);
        check("async rst rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("async rst wr_pending", {31'd0, bus.wr_pending}, 32'd0);
        check("async rst sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        $display("[TB] async reset asserted mid-burst -> rv=%0b rd_data=%08h pend=%0b sat=%0b",
                 bus.rd_valid, bus.rd_data, bus.wr_pending, bus.sat_flag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(0,1,1,0,0, 8'h62, 32'hA,32'hB,0, 0,8'h00, 0,0,1,0), "rst_e");
        run_vec(idle, "rst_f");
        run_vec(mk(0,0,0,0,0, 8'h00, 0,0,0, 1,8'h60, 1,0,0,0),     "rst_g");
        run_vec(mk(0,0,0,0,0, 8'h00, 0,0,0, 1,8'h61, 1,0,0,0),     "rst_h");
        run_vec(mk(0,0,0,0,0, 8'h00, 0,0,0, 1,8'h62, 1,32'hA,0,0), "rst_i");
        run_vec(mk(0,0,0,0,0, 8'h00, 0,0,0, 1,8'h70, 1,0,0,0),     "rst_j");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
